fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage of the soft processor; sits directly upstream of the 256x14 RAM.
//  Owns the program counter and drives the RAM address; the RAM read is combinational.
//  Latches each fetched word into an output register with a valid/ready handshake to decode.
//  Redirects on branches, stops on a HALT word and counts delivered instructions.
// PARAMETERS
//  AW       8      address width; PC wraps at 2**AW
//  DW       14     instruction width
//  RESET_PC 8'd0   PC value loaded on reset
//  HALT_OP  4'hF   opcode in instr[DW-1:DW-4] that halts fetch
// PORTS
//  clk            in   1    system clock; all state updates on posedge
//  rst_n          in   1    asynchronous, active-low reset
//  start          in   1    pulse: leave IDLE or HALT and begin or resume fetching
//  ram_addr       out  AW   RAM address, combinationally equal to pc
//  ram_data       in   DW   RAM read data for ram_addr, valid in the same cycle
//  instr          out  DW   registered instruction word to decode
//  instr_pc       out  AW   address that instr was fetched from
//  instr_valid    out  1    instr/instr_pc hold a valid instruction
//  instr_ready    in   1    decode accepts instr this cycle
//  branch_take    in   1    redirect request from execute
//  branch_target  in   AW   new PC when branch_take=1
//  halted         out  1    high while in HALT
//  fetch_count    out  16   delivered instructions, saturating at 16'hFFFF
// BEHAVIOUR
//  - Reset, async on rst_n=0: state=IDLE, pc=RESET_PC, instr=0, instr_pc=0,
//    instr_valid=0, halted=0, fetch_count=0.
//  - ram_addr=pc at all times. No RAM write port; this stage is read-only.
//  - States: IDLE, RUN, HALT.
//    IDLE: no fetch. start=1 moves to RUN next cycle.
//    RUN:  fetches every cycle the output slot is free.
//    HALT: halted=1, no fetch. start=1 moves to RUN; pc is already past the HALT word.
//  - Slot free = !instr_valid || instr_ready.
//  - RUN fetch, slot free, normal word:
//    instr<=ram_data, instr_pc<=pc, instr_valid<=1, pc<=pc+1.
//    Latency: the word at pc appears on instr one cycle after it is addressed.
//    Throughput: 1 instruction per cycle while instr_ready=1.
//  - RUN fetch, slot free, ram_data[DW-1:DW-4]==HALT_OP:
//    the word is not forwarded; instr_valid<=0, pc<=pc+1, state<=HALT.
//  - RUN, slot not free (instr_valid=1, instr_ready=0): instr, instr_pc and pc hold.
//  - A handshake (instr_valid && instr_ready) increments fetch_count; saturates, never wraps.
//  - branch_take=1 in RUN has highest priority, overriding stall and HALT detection:
//    pc<=branch_target, instr_valid<=0, and the word currently on ram_data is discarded.
//    If instr_ready=1 in the same cycle, the current instr is still counted as accepted.
//    The target word is fetched next cycle. branch_take is ignored in IDLE and HALT.
//  - start is ignored while in RUN.
//  - pc increments modulo 2**AW: 8'hFF -> 8'h00 with no flag.
//  - Reset asserted mid-operation aborts immediately: outputs return to reset values and
//    any pending instr is lost.
// TESTING
//  1. Reset, RAM[0..2]=1,2,3, start pulse, instr_ready=1 ->
//     instr 1,2,3 on consecutive cycles with instr_pc 0,1,2; fetch_count=3.
//  2. instr_ready=0 for 3 cycles while instr=2 -> instr, instr_pc=1 and pc=2 hold;
//     release -> 3 follows next cycle.
//  3. branch_take=1, branch_target=8'h40 while instr_valid=1 -> instr_valid=0 next cycle,
//     then instr=RAM[0x40], instr_pc=0x40.
//  4. RAM[3]=14'h3C00 (HALT) -> instr 1,2,3 delivered, halted=1, instr_valid=0, pc=4;
//     start -> RAM[4] delivered.
//  5. branch_target=8'hFF, instr_ready=1 -> instr_pc FF then 00, no stall.
//  6. rst_n low mid-stall -> instr_valid=0, pc=RESET_PC, fetch_count=0 without waiting for clk.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction fetch stage. Owns the program counter, addresses a
//             combinational-read instruction RAM, registers each fetched word
//             into a single output slot with a valid/ready handshake toward
//             decode, redirects on branches, stops on a HALT word and counts
//             delivered instructions.
//  Ports    : clk, rst_n         - clock, asynchronous active-low reset
//             start              - pulse: leave IDLE/HALT and begin fetching
//             ram_addr/ram_data  - RAM read address (== pc) and read data
//             instr, instr_pc    - registered instruction word and its address
//             instr_valid/ready  - handshake toward decode
//             branch_take/target - redirect request from execute
//             halted             - high while in HALT
//             fetch_count        - delivered instructions, saturating
//  Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
   parameter int unsigned     AW       = 8,
   parameter int unsigned     DW       = 14,
   parameter logic [AW-1:0]   RESET_PC = '0,
   parameter logic [3:0]      HALT_OP  = 4'hF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   output logic [AW-1:0]   ram_addr,
   input  logic [DW-1:0]   ram_data,
   output logic [DW-1:0]   instr,
   output logic [AW-1:0]   instr_pc,
   output logic            instr_valid,
   input  logic            instr_ready,
   input  logic            branch_take,
   input  logic [AW-1:0]   branch_target,
   output logic            halted,
   output logic [15:0]     fetch_count
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   state_t          state_q;
   logic [AW-1:0]   pc_q;
   logic [DW-1:0]   instr_q;
   logic [AW-1:0]   instr_pc_q;
   logic            instr_valid_q;
   logic            halted_q;
   logic [15:0]     fetch_count_q;

   logic [AW-1:0]   pc_inc_d;
   logic            slot_free_d;
   logic            is_halt_d;
   logic            handshake_d;

   // pc wraps naturally at 2**AW through truncation of the add.
   assign pc_inc_d    = pc_q + {{(AW-1){1'b0}}, 1'b1};
   assign slot_free_d = !instr_valid_q || instr_ready;
   assign is_halt_d   = (ram_data[DW-1 -: 4] == HALT_OP);
   assign handshake_d = instr_valid_q && instr_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         pc_q          <= RESET_PC;
         instr_q       <= '0;
         instr_pc_q    <= '0;
         instr_valid_q <= 1'b0;
         halted_q      <= 1'b0;
         fetch_count_q <= '0;
      end else begin
         // Acceptance is counted independently of the FSM so that a word
         // taken by decode in the same cycle as a branch still counts.
         if (handshake_d && (fetch_count_q != 16'hFFFF)) begin
            fetch_count_q <= fetch_count_q + 16'd1;
         end

         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q <= S_RUN;
               end
            end

            S_RUN: begin
               if (branch_take) begin
                  // Redirect wins over stall and HALT detection; the word
                  // currently on ram_data belongs to the wrong path.
                  pc_q          <= branch_target;
                  instr_valid_q <= 1'b0;
               end else if (slot_free_d) begin
                  pc_q <= pc_inc_d;
                  if (is_halt_d) begin
                     // HALT word is consumed but never forwarded; pc already
                     // points past it so a later start resumes cleanly.
                     instr_valid_q <= 1'b0;
                     halted_q      <= 1'b1;
                     state_q       <= S_HALT;
                  end else begin
                     instr_q       <= ram_data;
                     instr_pc_q    <= pc_q;
                     instr_valid_q <= 1'b1;
                  end
               end
            end

            S_HALT: begin
               if (start) begin
                  halted_q <= 1'b0;
                  state_q  <= S_RUN;
               end
            end

            default: begin
               state_q       <= S_IDLE;
               instr_valid_q <= 1'b0;
               halted_q      <= 1'b0;
            end
         endcase
      end
   end

   assign ram_addr    = pc_q;
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = instr_valid_q;
   assign halted      = halted_q;
   assign fetch_count = fetch_count_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Self-checking bench for fetch_unit. A behavioural RAM feeds the
//             DUT; expected {pc, instr} pairs are queued as stimulus is
//             planned and popped by a monitor on every decode handshake.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

   localparam int AW = 8;
   localparam int DW = 14;

   logic            clk;
   logic            rst_n;
   logic            start;
   logic [AW-1:0]   ram_addr;
   logic [DW-1:0]   ram_data;
   logic [DW-1:0]   instr;
   logic [AW-1:0]   instr_pc;
   logic            instr_valid;
   logic            instr_ready;
   logic            branch_take;
   logic [AW-1:0]   branch_target;
   logic            halted;
   logic [15:0]     fetch_count;

   logic [DW-1:0]   mem [0:255];
   logic [AW+DW-1:0] exp_q [$];

   int n_checks;
   int n_pass;

   fetch_unit #(
      .AW       (AW),
      .DW       (DW),
      .RESET_PC (8'd0),
      .HALT_OP  (4'hF)
   ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .ram_addr      (ram_addr),
      .ram_data      (ram_data),
      .instr         (instr),
      .instr_pc      (instr_pc),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .branch_take   (branch_take),
      .branch_target (branch_target),
      .halted        (halted),
      .fetch_count   (fetch_count)
   );

   assign ram_data = mem[ram_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [AW-1:0] pc, input logic [DW-1:0] w);
      exp_q.push_back({pc, w});
   endtask

   // Scoreboard monitor: every accepted word must match the queue head.
   always @(negedge clk) begin
      if (rst_n && instr_valid && instr_ready) begin
         if (exp_q.size() == 0) begin
            chk("sb_unexpected_word", exp_q.size(), 1);
         end else begin
            logic [AW+DW-1:0] e;
            e = exp_q.pop_front();
            chk("sb_instr", instr, e[DW-1:0]);
            chk("sb_instr_pc", instr_pc, e[AW+DW-1:DW]);
         end
      end
   end

   initial begin
      n_checks      = 0;
      n_pass        = 0;
      rst_n         = 1'b0;
      start         = 1'b0;
      instr_ready   = 1'b1;
      branch_take   = 1'b0;
      branch_target = '0;

      for (int i = 0; i < 256; i++) mem[i] = 14'h100 | 14'(i);
      mem[0] = 14'd1;
      mem[1] = 14'd2;
      mem[2] = 14'd3;
      mem[3] = 14'h3C00;
      mem[4] = 14'd5;

      // Reset state
      repeat (3) step();
      chk("rst_valid", instr_valid, 0);
      chk("rst_halted", halted, 0);
      chk("rst_count", fetch_count, 0);
      chk("rst_addr", ram_addr, 0);
      chk("rst_instr", instr, 0);
      chk("rst_instr_pc", instr_pc, 0);

      // IDLE does not fetch without start
      rst_n = 1'b1;
      step();
      step();
      chk("idle_addr", ram_addr, 0);
      chk("idle_valid", instr_valid, 0);

      // Streaming 1,2,3 then HALT at address 3
      push(8'd0, 14'd1);
      push(8'd1, 14'd2);
      push(8'd2, 14'd3);
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 20 && !halted; i++) step();
      chk("halt1_halted", halted, 1);
      chk("halt1_valid", instr_valid, 0);
      chk("halt1_addr", ram_addr, 8'd4);
      chk("halt1_count", fetch_count, 3);

      // Resume with decode stalled: word and pc must hold
      push(8'd4, 14'd5);
      push(8'd5, 14'h105);
      instr_ready = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("resume_halted", halted, 0);
      step();
      for (int i = 0; i < 3; i++) begin
         chk("stall_valid", instr_valid, 1);
         chk("stall_instr", instr, 14'd5);
         chk("stall_instr_pc", instr_pc, 8'd4);
         chk("stall_addr", ram_addr, 8'd5);
         step();
      end
      chk("stall_count", fetch_count, 3);

      // Release, then branch to 0x40 while a word is valid and accepted
      push(8'h40, 14'h140);
      push(8'h41, 14'h141);
      instr_ready = 1'b1;
      step();
      chk("pre_br_instr", instr, 14'h105);
      branch_take   = 1'b1;
      branch_target = 8'h40;
      chk("pre_br_valid", instr_valid, 1);
      step();
      branch_take = 1'b0;
      chk("br_valid", instr_valid, 0);
      chk("br_addr", ram_addr, 8'h40);
      chk("br_count", fetch_count, 5);
      step();
      chk("br_tgt_instr", instr, 14'h140);
      chk("br_tgt_pc", instr_pc, 8'h40);
      step();

      // Branch to 0xFF: wrap FF -> 00 with no bubble, then halt again at 3
      push(8'hFF, 14'h1FF);
      push(8'h00, 14'd1);
      push(8'h01, 14'd2);
      push(8'h02, 14'd3);
      branch_take   = 1'b1;
      branch_target = 8'hFF;
      step();
      branch_take = 1'b0;
      step();
      chk("wrap_pc_ff", instr_pc, 8'hFF);
      chk("wrap_addr", ram_addr, 8'h00);
      step();
      chk("wrap_pc_00", instr_pc, 8'h00);
      chk("wrap_valid", instr_valid, 1);
      for (int i = 0; i < 20 && !halted; i++) step();
      chk("halt2_halted", halted, 1);
      chk("halt2_count", fetch_count, 11);
      chk("halt2_addr", ram_addr, 8'd4);
      chk("sb_drained", exp_q.size(), 0);

      // Asynchronous reset in the middle of a stall
      instr_ready = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      chk("pre_rst_valid", instr_valid, 1);
      step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", instr_valid, 0);
      chk("arst_addr", ram_addr, 8'd0);
      chk("arst_count", fetch_count, 0);
      chk("arst_halted", halted, 0);
      chk("arst_instr", instr, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
